// File: rtl/serial_shift_right_pkg.sv
// Shared constants for the bit-serial right shifter: FSM encodings and fill modes.
package serial_shift_right_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/serial_shift_right.sv
// Bit-serial right shifter: one bit per clock, logical or arithmetic fill,
// fixed latency of shamt+1 cycles from acceptance to the done pulse.
module serial_shift_right
    import serial_shift_right_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [SHW-1:0]   cnt;
    logic             mode;
    logic             fill;

    // Arithmetic mode replicates the current MSB; logical mode shifts in zero.
    assign fill   = (mode == SHIFT_ARITH) ? sreg[WIDTH-1] : 1'b0;
    assign result = sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            mode  <= SHIFT_LOGICAL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg <= data_in;
                        cnt  <= shamt;
                        mode <= arith;
                        busy <= 1'b1;
                        if (shamt != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= {fill, sreg[WIDTH-1:1]};
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_right.sv
// Scoreboard bench for serial_shift_right: expected result and latency queued at
// stimulus time, popped and compared on each done pulse.
module tb_serial_shift_right;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    serial_shift_right #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int sh, input logic ar);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < sh; i++) r = {ar ? r[WIDTH-1] : 1'b0, r[WIDTH-1:1]};
        return r;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] d, input int sh, input logic ar);
        exp_t e;
        e.res = model(d, sh, ar);
        e.lat = sh + 1;
        return e;
    endfunction

    // Pop the head of the scoreboard and compare against the current outputs.
    task automatic retire(input string tag, input int cycles);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_latency"}, 32'(cycles), 32'(e.lat));
        end
    endtask

    // Drive one operation; optional input scrambling and a start collision while busy.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int sh,
                          input logic ar, input bit scramble, input int collide);
        int  cycles;
        bit  seen;
        int  extra;
        logic [WIDTH-1:0] held;
        q.push_back(mk(d, sh, ar));
        @(negedge clk);
        data_in = d; shamt = SHW'(sh); arith = ar; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                retire(tag, cycles);
                held = result;
            end else begin
                if (scramble) begin
                    data_in = $urandom; shamt = SHW'($urandom); arith = 1'($urandom);
                end
                if (collide > 0 && cycles == collide) begin
                    data_in = '1; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
            q.delete();
        end else begin
            @(negedge clk);
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
            chk({tag, "_held"}, result, held);
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                if (done || busy) extra++;
                @(negedge clk);
            end
            chk({tag, "_no_extra_op"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int cycles;
        int ndone;
        reset = 1'b1; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0;
        #3;
        chk("reset_result", result, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_op("srl4",     32'h8000_0000, 4,  1'b0, 1'b0, 0);
        run_op("sra4",     32'h8000_0000, 4,  1'b1, 1'b0, 0);
        run_op("sra31",    32'h8000_0000, 31, 1'b1, 1'b0, 0);
        run_op("srl31",    32'h8000_0000, 31, 1'b0, 1'b0, 0);
        run_op("zero",     32'h1234_5678, 0,  1'b0, 1'b0, 0);
        run_op("zero_ar",  32'h8765_4321, 0,  1'b1, 1'b0, 0);
        run_op("collide",  32'h0F0F_0000, 6,  1'b0, 1'b0, 2);
        run_op("scramble", 32'hA5A5_A5A5, 12, 1'b1, 1'b1, 0);
        for (int i = 0; i < 6; i++)
            run_op("rand", $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'b1, 0);

        // Start held high: second operation accepted after exactly one idle cycle.
        q.push_back(mk(32'hF000_0000, 2, 1'b1));
        @(negedge clk);
        data_in = 32'hF000_0000; shamt = 5'd2; arith = 1'b1; start = 1'b1;
        @(posedge clk);
        cycles = 0; ndone = 0;
        while (ndone < 2 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                data_in = 32'h0000_0F00; shamt = 5'd1; arith = 1'b0;
                q.push_back(mk(32'h0000_0F00, 1, 1'b0));
            end
            if (cycles == 4) chk("held_idle_gap", 32'(busy), 32'd0);
            if (done) begin
                ndone++;
                // Second op: accepted at edge 4, so its latency is measured from there.
                retire("held", (ndone == 1) ? cycles : cycles - 4);
            end
        end
        chk("held_two_ops", 32'(ndone), 32'd2);
        start = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);

        // Reset two cycles into a long shift aborts it with no trailing done.
        @(negedge clk);
        data_in = 32'hDEAD_BEEF; shamt = 5'd10; arith = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        run_op("post_rst", 32'h0000_0100, 8, 1'b0, 1'b0, 0);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
